// File: rtl/kvs_rx_pkt_fifo.sv
// kvs_rx_pkt_fifo
// Store-and-forward AXI-Stream ingress FIFO between the network RX and the KVS
// parser. The MAC side is never back-pressured. A packet becomes visible on the
// egress side only once its tlast beat is stored. Packets that do not fit, or
// that exceed MAX_PKT_WORDS beats, are discarded whole by rewinding the write
// pointer to the last commit point.
//
// Pointer scheme (all DEPTH_LOG2+1 bits, natural binary wrap):
//   wr_ptr     next entry to write (includes uncommitted beats)
//   commit_ptr end of the last complete packet
//   fetch_ptr  next entry to read from the memory into the egress pipeline
//   rd_ptr     next entry to hand over on m_axis (advances on handshake)
// Occupancy is taken against rd_ptr, so beats held in the egress pipeline
// still reserve their memory slot until the consumer has accepted them.
module kvs_rx_pkt_fifo #(
  parameter int DEPTH_LOG2    = 9,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                  from_net_clk_390,
  input  logic                  from_net_clk_390_rst_n,
  input  logic [63:0]           s_axis_tdata,
  input  logic [7:0]            s_axis_tkeep,
  input  logic [63:0]           s_axis_tuser,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic [63:0]           m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [31:0]           stat_rx_pkts,
  output logic [31:0]           stat_drop_pkts,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int PTR_W   = DEPTH_LOG2 + 1;
  localparam int ENTRY_W = 137;
  localparam int CNT_W   = $clog2(MAX_PKT_WORDS + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } ing_state_t;

  // Entry layout: {tlast, tuser, tkeep, tdata}
  logic [ENTRY_W-1:0]    r_mem [0:DEPTH-1];

  ing_state_t            r_state;
  ing_state_t            w_state_nxt;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_commit_ptr;
  logic [PTR_W-1:0]      r_fetch_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [CNT_W-1:0]      w_beat_cnt_nxt;
  logic [31:0]           r_stat_rx;
  logic [31:0]           r_stat_drop;
  logic                  r_tready;

  logic                  w_beat;
  logic [PTR_W-1:0]      w_occ;
  logic                  w_full;
  logic                  w_wr_en;
  logic                  w_rewind;
  logic                  w_commit;
  logic                  w_drop_inc;
  logic [ENTRY_W-1:0]    w_wr_entry;

  logic [ENTRY_W-1:0]    r_rdata_p1;
  logic                  r_rd_vld_p1;
  logic [63:0]           r_out_tdata_p2;
  logic [7:0]            r_out_tkeep_p2;
  logic [63:0]           r_out_tuser_p2;
  logic                  r_out_tlast_p2;
  logic                  r_out_vld_p2;

  logic                  w_out_free;
  logic                  w_move;
  logic                  w_fetch;
  logic                  w_out_fire;

  assign w_beat     = s_axis_tvalid & r_tready;
  assign w_occ      = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_occ == FULL_OCC);
  assign w_wr_entry = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

  // Ingress stage: the MAC is accepted every cycle once out of reset
  always_ff @(posedge from_net_clk_390 or negedge from_net_clk_390_rst_n) begin
    if (!from_net_clk_390_rst_n) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= 1'b1;
    end
  end

  // Ingress FSM state register
  always_ff @(posedge from_net_clk_390 or negedge from_net_clk_390_rst_n) begin
    if (!from_net_clk_390_rst_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Ingress FSM decisions: write, commit, or discard the current beat
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_wr_en        = 1'b0;
    w_rewind       = 1'b0;
    w_commit       = 1'b0;
    w_drop_inc     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          if (w_full) begin
            // wr_ptr already equals commit_ptr here, nothing to rewind
            w_drop_inc  = s_axis_tlast;
            w_state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else begin
            w_wr_en        = 1'b1;
            w_beat_cnt_nxt = CNT_ONE;
            if (s_axis_tlast) begin
              w_commit = 1'b1;
            end else begin
              w_state_nxt = ST_RECV;
            end
          end
        end
      end
      ST_RECV: begin
        if (w_beat) begin
          if (w_full || (r_beat_cnt == MAX_CNT)) begin
            w_rewind    = 1'b1;
            w_drop_inc  = s_axis_tlast;
            w_state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else begin
            w_wr_en        = 1'b1;
            w_beat_cnt_nxt = r_beat_cnt + CNT_ONE;
            if (s_axis_tlast) begin
              w_commit    = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        if (w_beat && s_axis_tlast) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write and commit pointers plus packet statistics
  always_ff @(posedge from_net_clk_390 or negedge from_net_clk_390_rst_n) begin
    if (!from_net_clk_390_rst_n) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_stat_rx    <= '0;
      r_stat_drop  <= '0;
    end else begin
      if (w_rewind) begin
        r_wr_ptr <= r_commit_ptr;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_commit) begin
        r_commit_ptr <= r_wr_ptr + PTR_ONE;
        r_stat_rx    <= r_stat_rx + 32'd1;
      end
      if (w_drop_inc) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
    end
  end

  // Packet buffer write port
  always_ff @(posedge from_net_clk_390) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_wr_entry;
    end
  end

  // ---- egress stage p1: memory read (one cycle latency) ----
  // The read register may only be refilled when its current beat moves on,
  // and only committed entries are ever fetched.
  assign w_out_free = ~r_out_vld_p2 | m_axis_tready;
  assign w_move     = r_rd_vld_p1 & w_out_free;
  assign w_fetch    = (r_fetch_ptr != r_commit_ptr) & (~r_rd_vld_p1 | w_move);
  assign w_out_fire = r_out_vld_p2 & m_axis_tready;

  // Packet buffer read port
  always_ff @(posedge from_net_clk_390) begin
    if (w_fetch) begin
      r_rdata_p1 <= r_mem[r_fetch_ptr[DEPTH_LOG2-1:0]];
    end
  end

  // Fetch pointer, read-valid flag and consumer pointer
  always_ff @(posedge from_net_clk_390 or negedge from_net_clk_390_rst_n) begin
    if (!from_net_clk_390_rst_n) begin
      r_fetch_ptr <= '0;
      r_rd_vld_p1 <= 1'b0;
      r_rd_ptr    <= '0;
    end else begin
      if (w_fetch) begin
        r_fetch_ptr <= r_fetch_ptr + PTR_ONE;
      end
      r_rd_vld_p1 <= w_fetch | (r_rd_vld_p1 & ~w_move);
      if (w_out_fire) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // ---- egress stage p2: output register, holds while the consumer stalls ----
  always_ff @(posedge from_net_clk_390 or negedge from_net_clk_390_rst_n) begin
    if (!from_net_clk_390_rst_n) begin
      r_out_vld_p2   <= 1'b0;
      r_out_tdata_p2 <= '0;
      r_out_tkeep_p2 <= '0;
      r_out_tuser_p2 <= '0;
      r_out_tlast_p2 <= 1'b0;
    end else if (w_out_free) begin
      r_out_vld_p2 <= r_rd_vld_p1;
      if (w_move) begin
        r_out_tdata_p2 <= r_rdata_p1[63:0];
        r_out_tkeep_p2 <= r_rdata_p1[71:64];
        r_out_tuser_p2 <= r_rdata_p1[135:72];
        r_out_tlast_p2 <= r_rdata_p1[136];
      end
    end
  end

  assign s_axis_tready  = r_tready;
  assign m_axis_tvalid  = r_out_vld_p2;
  assign m_axis_tdata   = r_out_tdata_p2;
  assign m_axis_tkeep   = r_out_tkeep_p2;
  assign m_axis_tuser   = r_out_tuser_p2;
  assign m_axis_tlast   = r_out_tlast_p2;
  assign stat_rx_pkts   = r_stat_rx;
  assign stat_drop_pkts = r_stat_drop;
  assign fifo_level     = r_commit_ptr - r_rd_ptr;

endmodule

// File: tb/tb_kvs_rx_pkt_fifo.sv
// Bench for kvs_rx_pkt_fifo. Two instances: dut_a is shallow (16 entries) for
// overflow, wrap and reset scenarios; dut_b is deep with an 8-beat packet limit
// for oversize and long random traffic. 'sel' routes stimulus to one of them.
`timescale 1ns/1ps
module tb_kvs_rx_pkt_fifo;

  typedef struct packed {
    logic        l;
    logic [63:0] u;
    logic [7:0]  k;
    logic [63:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic [63:0] s_tuser;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_tready;

  logic        a_vld_in, b_vld_in, a_rdy_in, b_rdy_in;
  logic        a_s_tready, b_s_tready;
  logic [63:0] a_tdata, b_tdata, a_tuser, b_tuser;
  logic [7:0]  a_tkeep, b_tkeep;
  logic        a_tvalid, b_tvalid, a_tlast, b_tlast;
  logic [31:0] a_rx, b_rx, a_drop, b_drop;
  logic [4:0]  a_level;
  logic [9:0]  b_level;

  assign a_vld_in = s_tvalid & ~sel;
  assign b_vld_in = s_tvalid & sel;
  assign a_rdy_in = m_tready & ~sel;
  assign b_rdy_in = m_tready & sel;

  kvs_rx_pkt_fifo #(.DEPTH_LOG2(4), .MAX_PKT_WORDS(16)) dut_a (
    .from_net_clk_390(clk), .from_net_clk_390_rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(a_vld_in), .s_axis_tlast(s_tlast), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tuser(a_tuser),
    .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast), .m_axis_tready(a_rdy_in),
    .stat_rx_pkts(a_rx), .stat_drop_pkts(a_drop), .fifo_level(a_level)
  );

  kvs_rx_pkt_fifo #(.DEPTH_LOG2(9), .MAX_PKT_WORDS(8)) dut_b (
    .from_net_clk_390(clk), .from_net_clk_390_rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(b_vld_in), .s_axis_tlast(s_tlast), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tuser(b_tuser),
    .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast), .m_axis_tready(b_rdy_in),
    .stat_rx_pkts(b_rx), .stat_drop_pkts(b_drop), .fifo_level(b_level)
  );

  logic        o_tvalid;
  beat_t       o_beat;
  logic [31:0] o_rx, o_drop;
  logic [9:0]  o_level;
  assign o_tvalid = sel ? b_tvalid : a_tvalid;
  assign o_beat   = sel ? {b_tlast, b_tuser, b_tkeep, b_tdata} : {a_tlast, a_tuser, a_tkeep, a_tdata};
  assign o_rx     = sel ? b_rx : a_rx;
  assign o_drop   = sel ? b_drop : a_drop;
  assign o_level  = sel ? b_level : {5'd0, a_level};

  int    n_checks = 0;
  int    n_errs   = 0;
  int    exp_rx_a = 0, exp_drop_a = 0, exp_rx_b = 0, exp_drop_b = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  bit    t5_done;

  // Output collector: a beat is taken at the edge following this sample
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_tvalid === 1'b1 && m_tready === 1'b1) got_q.push_back(o_beat);
  end

  function automatic beat_t mk_beat(logic [63:0] d, logic [7:0] k, logic [63:0] u, logic l);
    beat_t b;
    b.d = d; b.k = k; b.u = u; b.l = l;
    return b;
  endfunction

  // Packet admission rule: fits in remaining space and within the beat limit
  function automatic bit pkt_accepted(int len, int occ, int depth, int max_words);
    return (len <= max_words) && (occ + len <= depth);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input beat_t b, input bit keep);
    s_tvalid = 1'b1; s_tdata = b.d; s_tkeep = b.k; s_tuser = b.u; s_tlast = b.l;
    if (keep) exp_q.push_back(b);
    tick();
  endtask

  task automatic send_pkt(input int len, input bit keep);
    for (int i = 0; i < len; i++)
      drive_beat(mk_beat({$urandom, $urandom}, 8'($urandom), {$urandom, $urandom}, (i == len - 1)), keep);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_drain(output bit to);
    m_tready = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (got_q.size() >= exp_q.size()) begin to = 1'b0; break; end
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; sel = 1'b0; m_tready = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (a_s_tready !== 1'b0) begin n_errs++; $display("FAIL rst_tready_a: got %b want 0", a_s_tready); end
    n_checks++; if (b_s_tready !== 1'b0) begin n_errs++; $display("FAIL rst_tready_b: got %b want 0", b_s_tready); end
    n_checks++; if ({a_tvalid, a_tlast} !== 2'b00) begin n_errs++; $display("FAIL rst_valid_last: got %b want 00", {a_tvalid, a_tlast}); end
    n_checks++; if ({a_tdata, a_tkeep, a_tuser} !== 136'd0) begin n_errs++; $display("FAIL rst_data: got %h want 0", {a_tdata, a_tkeep, a_tuser}); end
    n_checks++; if ({a_rx, a_drop, a_level} !== 69'd0) begin n_errs++; $display("FAIL rst_stats: got %h want 0", {a_rx, a_drop, a_level}); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_checks++; if ({a_s_tready, b_s_tready} !== 2'b11) begin n_errs++; $display("FAIL post_rst_tready: got %b want 11", {a_s_tready, b_s_tready}); end
    n_checks++; if (b_tvalid !== 1'b0) begin n_errs++; $display("FAIL post_rst_valid_b: got %b want 0", b_tvalid); end
    tick();
  endtask

  task automatic test_single();
    bit to;
    sel = 1'b0; m_tready = 1'b1;
    drive_beat(mk_beat(64'h1111111111111111, 8'hFF, 64'hA5, 1'b0), 1'b1);
    drive_beat(mk_beat(64'h2222222222222222, 8'hFF, 64'hA5, 1'b0), 1'b1);
    drive_beat(mk_beat(64'h3333333333333333, 8'h0F, 64'hA5, 1'b1), 1'b1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    exp_rx_a++;
    @(negedge clk);
    n_checks++; if (o_level !== 10'd3) begin n_errs++; $display("FAIL t1_level: got %0d want 3", o_level); end
    n_checks++; if (o_rx !== 32'(exp_rx_a)) begin n_errs++; $display("FAIL t1_rx_early: got %0d want %0d", o_rx, exp_rx_a); end
    @(negedge clk);
    n_checks++; if (o_tvalid !== 1'b0) begin n_errs++; $display("FAIL t1_lat_early: tvalid got %b want 0", o_tvalid); end
    @(negedge clk);
    n_checks++; if (o_tvalid !== 1'b1) begin n_errs++; $display("FAIL t1_lat: tvalid got %b want 1", o_tvalid); end
    wait_drain(to);
    n_checks++; if (to) begin n_errs++; $display("FAIL t1_timeout: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_errs++; $display("FAIL t1_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errs++; $display("FAIL t1_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (o_level !== 10'd0) begin n_errs++; $display("FAIL t1_level_end: got %0d want 0", o_level); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    bit    to, prev_stall;
    beat_t snap;
    sel = 1'b0; m_tready = 1'b0;
    send_pkt(5, 1'b1);
    exp_rx_a++;
    prev_stall = 1'b0; snap = '0;
    for (int c = 0; c < 60; c++) begin
      if (got_q.size() >= 5) break;
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (o_tvalid !== 1'b1 || o_beat !== snap) begin
          n_errs++; $display("FAIL t2_hold: got %b/%h want 1/%h", o_tvalid, o_beat, snap);
        end
      end
      prev_stall = o_tvalid && !m_tready;
      snap = o_beat;
      @(posedge clk); #1;
      m_tready = ~m_tready;
    end
    wait_drain(to);
    n_checks++; if (to) begin n_errs++; $display("FAIL t2_timeout: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_errs++; $display("FAIL t2_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errs++; $display("FAIL t2_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (o_rx !== 32'(exp_rx_a)) begin n_errs++; $display("FAIL t2_rx: got %0d want %0d", o_rx, exp_rx_a); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    bit to, keep;
    int occ;
    int lens[4] = '{10, 10, 6, 1};
    sel = 1'b0; m_tready = 1'b0; occ = 0;
    foreach (lens[p]) begin
      keep = pkt_accepted(lens[p], occ, 16, 16);
      if (keep) begin occ += lens[p]; exp_rx_a++; end else exp_drop_a++;
      send_pkt(lens[p], keep);
    end
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (o_level !== 10'(occ)) begin n_errs++; $display("FAIL t3_level: got %0d want %0d", o_level, occ); end
    n_checks++; if (o_drop !== 32'(exp_drop_a)) begin n_errs++; $display("FAIL t3_drop: got %0d want %0d", o_drop, exp_drop_a); end
    n_checks++; if (o_rx !== 32'(exp_rx_a)) begin n_errs++; $display("FAIL t3_rx: got %0d want %0d", o_rx, exp_rx_a); end
    tick();
    wait_drain(to);
    n_checks++; if (to) begin n_errs++; $display("FAIL t3_timeout: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_errs++; $display("FAIL t3_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errs++; $display("FAIL t3_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (o_level !== 10'd0) begin n_errs++; $display("FAIL t3_level_end: got %0d want 0", o_level); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_oversize();
    bit to, keep;
    int lens[3] = '{9, 2, 8};
    sel = 1'b1; m_tready = 1'b1;
    foreach (lens[p]) begin
      keep = pkt_accepted(lens[p], 0, 512, 8);
      if (keep) exp_rx_b++; else exp_drop_b++;
      send_pkt(lens[p], keep);
    end
    wait_drain(to);
    n_checks++; if (to) begin n_errs++; $display("FAIL t4_timeout: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_errs++; $display("FAIL t4_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errs++; $display("FAIL t4_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (o_drop !== 32'(exp_drop_b)) begin n_errs++; $display("FAIL t4_drop: got %0d want %0d", o_drop, exp_drop_b); end
    n_checks++; if (o_rx !== 32'(exp_rx_b)) begin n_errs++; $display("FAIL t4_rx: got %0d want %0d", o_rx, exp_rx_b); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    bit to;
    sel = 1'b1; t5_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          send_pkt(int'($urandom_range(1, 8)), 1'b1);
          exp_rx_b++;
        end
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          m_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    wait_drain(to);
    n_checks++; if (to) begin n_errs++; $display("FAIL t5_timeout: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_errs++; $display("FAIL t5_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errs++; $display("FAIL t5_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (o_rx !== 32'(exp_rx_b)) begin n_errs++; $display("FAIL t5_rx: got %0d want %0d", o_rx, exp_rx_b); end
    n_checks++; if (o_drop !== 32'(exp_drop_b)) begin n_errs++; $display("FAIL t5_drop: got %0d want %0d", o_drop, exp_drop_b); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wrap();
    bit to;
    sel = 1'b0; m_tready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      send_pkt(int'($urandom_range(1, 8)), 1'b1);
      exp_rx_a++;
    end
    wait_drain(to);
    n_checks++; if (to) begin n_errs++; $display("FAIL wrap_timeout: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_errs++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errs++; $display("FAIL wrap_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (o_rx !== 32'(exp_rx_a)) begin n_errs++; $display("FAIL wrap_rx: got %0d want %0d", o_rx, exp_rx_a); end
    n_checks++; if (o_drop !== 32'(exp_drop_a)) begin n_errs++; $display("FAIL wrap_drop: got %0d want %0d", o_drop, exp_drop_a); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    bit to;
    sel = 1'b0; m_tready = 1'b0;
    send_pkt(2, 1'b0);
    drive_beat(mk_beat({$urandom, $urandom}, 8'hFF, {$urandom, $urandom}, 1'b0), 1'b0);
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = {$urandom, $urandom};
    #2 rst_n = 1'b0;
    #1;
    exp_rx_a = 0; exp_drop_a = 0; exp_rx_b = 0; exp_drop_b = 0;
    n_checks++; if ({a_tvalid, a_tlast} !== 2'b00) begin n_errs++; $display("FAIL t6_valid: got %b want 00", {a_tvalid, a_tlast}); end
    n_checks++; if (a_s_tready !== 1'b0) begin n_errs++; $display("FAIL t6_tready: got %b want 0", a_s_tready); end
    n_checks++; if ({a_tdata, a_tkeep, a_tuser} !== 136'd0) begin n_errs++; $display("FAIL t6_data: got %h want 0", {a_tdata, a_tkeep, a_tuser}); end
    n_checks++; if ({a_rx, a_drop, a_level} !== 69'd0) begin n_errs++; $display("FAIL t6_stats: got %h want 0", {a_rx, a_drop, a_level}); end
    s_tvalid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick(); tick();
    exp_q.delete(); got_q.delete();
    m_tready = 1'b1;
    send_pkt(2, 1'b1);
    exp_rx_a++;
    wait_drain(to);
    n_checks++; if (to) begin n_errs++; $display("FAIL t6_timeout: got %0d beats want %0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_errs++; $display("FAIL t6_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errs++; $display("FAIL t6_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (o_rx !== 32'(exp_rx_a)) begin n_errs++; $display("FAIL t6_rx: got %0d want %0d", o_rx, exp_rx_a); end
    n_checks++; if (o_drop !== 32'(exp_drop_a)) begin n_errs++; $display("FAIL t6_drop: got %0d want %0d", o_drop, exp_drop_a); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_oversize();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
